// File: rtl/psddiv_arbiter.sv
// psddiv_arbiter: round-robin front end that shares one sequential divider core
// among NREQ requesters, sequencing start/stop pulses and returning tagged results.
module psddiv_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 32,
  parameter int ITERATIONS  = 32,
  parameter int RESULT_WAIT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_dividend,
  input  logic [NREQ*WIDTH-1:0]   req_divisor,
  output logic                    div_start,
  output logic                    div_stop,
  output logic [WIDTH-1:0]        div_dividend,
  output logic [WIDTH-1:0]        div_divisor,
  input  logic [WIDTH-1:0]        div_quotient,
  input  logic [WIDTH-1:0]        div_rest,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [WIDTH-1:0]        resp_quotient,
  output logic [WIDTH-1:0]        resp_rest,
  output logic                    resp_divzero,
  output logic                    busy
);
  localparam int IDW     = $clog2(NREQ);
  localparam int CNT_MAX = (ITERATIONS > RESULT_WAIT) ? ITERATIONS : RESULT_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  ITER_LAST = CW'(ITERATIONS - 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(RESULT_WAIT - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STOP = 3'd3,
    ST_WAIT = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  state_t           state_r, state_next_s;
  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_id_s;
  logic             grant_found_s;
  logic             accept_s;
  logic             divzero_s;
  logic             wait_done_s;
  logic [WIDTH-1:0] sel_dividend_s;
  logic [WIDTH-1:0] sel_divisor_s;

  // Round-robin search: descending loop so the lowest offset from the pointer wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int  idx;
      logic hit;
      idx           = int'(ptr_r) + k;
      idx           = (idx >= NREQ) ? idx - NREQ : idx;
      hit           = req_valid[IDW'(idx)];
      grant_id_s    = hit ? IDW'(idx) : grant_id_s;
      grant_found_s = grant_found_s | hit;
    end
  end

  assign accept_s       = (state_r == ST_IDLE) && grant_found_s && !reset;
  assign req_ready      = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id_s) : '0;
  assign sel_dividend_s = req_dividend[grant_id_s*WIDTH +: WIDTH];
  assign sel_divisor_s  = req_divisor[grant_id_s*WIDTH +: WIDTH];
  assign divzero_s      = (sel_divisor_s == {WIDTH{1'b0}});
  assign wait_done_s    = (state_r == ST_WAIT) && (cnt_r == WAIT_LAST);

  // Next-state and iteration/wait counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = divzero_s ? ST_RESP : ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next_s = ST_RUN;
        cnt_next_s   = '0;
      end
      ST_RUN: begin
        if (cnt_r == ITER_LAST) begin
          state_next_s = ST_STOP;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + 1'b1;
        end
      end
      ST_STOP: begin
        state_next_s = ST_WAIT;
        cnt_next_s   = '0;
      end
      ST_WAIT: begin
        if (wait_done_s) begin
          state_next_s = ST_RESP;
        end else begin
          cnt_next_s   = cnt_r + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Registered outputs: control pulses decoded from the next state, operand and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r         <= '0;
      div_start     <= 1'b0;
      div_stop      <= 1'b0;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      resp_id       <= '0;
      resp_quotient <= '0;
      resp_rest     <= '0;
      resp_divzero  <= 1'b0;
    end else begin
      div_start  <= (state_next_s == ST_LOAD);
      div_stop   <= (state_next_s == ST_STOP);
      busy       <= (state_next_s != ST_IDLE);
      resp_valid <= (state_next_s == ST_RESP);
      if (accept_s) begin
        div_dividend <= sel_dividend_s;
        div_divisor  <= sel_divisor_s;
        resp_id      <= grant_id_s;
        ptr_r        <= (grant_id_s == LAST_ID) ? '0 : grant_id_s + 1'b1;
        // Zero divisor never touches the core; answer is fixed here.
        if (divzero_s) begin
          resp_quotient <= {WIDTH{1'b1}};
          resp_rest     <= sel_dividend_s;
          resp_divzero  <= 1'b1;
        end
      end else if (wait_done_s) begin
        resp_quotient <= div_quotient;
        resp_rest     <= div_rest;
        resp_divzero  <= 1'b0;
      end
    end
  end
endmodule
